eth_clk_ctrl: RTL and testbench
===============================

Name: eth_clk_ctrl

Overview:
Speed-select controller for the Ethernet TX clock generator. It divides rx_clk125 into the 10 Mbps (2.5 MHz) or 100 Mbps (25 MHz) TX clock, or requests bypass for 1000 Mbps (125 MHz direct).
- Filters the PHY speed indication and switches ratios glitch-free: it drains the current period, then holds the clock low, before loading the new divisor.
- Sits between PHY status logic and the TX MAC clock mux.

Parameters:
- DIV_10, 50: divide ratio for 10 Mbps.
- DIV_100, 5: divide ratio for 100 Mbps.
- CNT_W, 6: divider counter width. Must satisfy 2^CNT_W > max(DIV_10, DIV_100).
- STABLE_CYC, 16: consecutive cycles speed_req must be constant before it is accepted.
- HOLD_CYC, 8: cycles tx_clk is held low between ratios.

Ports:
- rx_clk125, input, 1: 125 MHz clock. Sole clock domain.
- reset_n, input, 1: asynchronous, active-low reset.
- speed_req, input, 2: requested speed. 00=10M, 01=100M, 10=1000M, 11=reserved. Synchronous to rx_clk125.
- tx_clk, output, 1: registered divided clock. Held 0 in bypass and during switching.
- tx_ce, output, 1: one-cycle enable coincident with each tx_clk rising edge. Constant 1 in bypass.
- clk_bypass, output, 1: 1 = downstream mux selects rx_clk125 directly.
- speed_cur, output, 2: speed currently in effect.
- busy, output, 1: high while a switch is in progress (DRAIN/HOLD/LOAD).
- switch_done, output, 1: one-cycle pulse when a new speed takes effect.

Behaviour:
- Reset (async assert, sync release):
  - speed_cur=00, state=RUN, counter=0.
  - tx_clk=0, tx_ce=0, clk_bypass=0, busy=0, switch_done=0.
  - Filter candidate=00, stab_cnt=0.
- Divider, RUN state, speed_cur 00 or 01, div = DIV_10 or DIV_100:
  - counter counts 0..div-1, then wraps to 0.
  - tx_clk <= (counter < div/2), integer floor. 10M: 25 high / 25 low. 100M: 2 high / 3 low.
  - tx_ce <= (counter == 0), so it is high in the same cycle tx_clk goes high.
- Bypass, RUN state, speed_cur=10:
  - counter held 0, tx_clk=0, tx_ce=1, clk_bypass=1.
- Filter:
  - If speed_req != candidate: candidate <= speed_req, stab_cnt <= 0.
  - Otherwise stab_cnt increments, saturating at STABLE_CYC.
  - A request is accepted when all hold: stab_cnt == STABLE_CYC-1 and still equal; state == RUN; candidate != speed_cur; candidate != 11.
  - On acceptance, target <= candidate and the FSM goes to DRAIN.
  - Reserved value 11 is never accepted, and the current speed continues.
- FSM:
  - RUN: as above. Leaves to DRAIN on acceptance; busy rises the cycle after acceptance.
  - DRAIN: divider keeps running until counter == div-1, so tx_clk is low and the period completes, then goes to HOLD. From bypass, DRAIN lasts exactly 1 cycle. No tx_clk high pulse is ever truncated.
  - HOLD: tx_clk=0, tx_ce=0, clk_bypass=0, for exactly HOLD_CYC cycles; then goes to LOAD.
  - LOAD: 1 cycle. speed_cur <= target, counter <= 0, clk_bypass <= (target == 10); then goes to RUN.
  - switch_done pulses in the first RUN cycle after LOAD, and busy falls in that same cycle.
  - The first tx_ce/rising edge at the new ratio occurs on that first RUN cycle. In bypass, tx_ce=1 from that cycle.
- During DRAIN/HOLD/LOAD:
  - speed_req changes still update the filter, but target is frozen.
  - A differing stable request is serviced only after returning to RUN; it needs a fresh acceptance, with stab_cnt counting continuously.
- Reset asserted in any state returns everything to reset values immediately; tx_clk is forced 0 asynchronously.
- No combinational path from any input to any output. All outputs are registers.

Test Plan:
- Release reset, speed_req=00 -> tx_clk period 50 cycles (25 high / 25 low); tx_ce one pulse per 50 cycles, aligned with the rising edge; busy=0.
- speed_req=01 held -> acceptance after 16 cycles; busy; current period completes; tx_clk low for at least 8 cycles; switch_done pulses once; then period 5 (2 high / 3 low); speed_cur=01; no high pulse shorter than its ratio's nominal width.
- speed_req=01 for 10 cycles, then back to 00 -> no acceptance; busy stays 0; tx_clk 50-cycle period uninterrupted.
- speed_req=10 from 100M -> after switch, clk_bypass=1, tx_clk=0, tx_ce=1 constant, speed_cur=10. Then speed_req=00 -> DRAIN 1 cycle, 8-cycle hold, back to a 50-cycle period.
- speed_req=11 held for 100 cycles -> ignored; speed_cur and tx_clk unchanged.
- reset_n pulsed low mid-HOLD during a 10M->100M switch -> immediate reset values; after release, speed_cur=00 and the 50-cycle period resumes.

Source files
------------

// File: rtl/eth_clk_ctrl.sv
// eth_clk_ctrl: speed-select controller for the Ethernet TX clock generator.
// Divides rx_clk125 down to 2.5 MHz (10M) or 25 MHz (100M), or requests bypass for 1000M.
// A requested speed must be stable for STABLE_CYC cycles before it is accepted. A ratio
// change drains the current period, holds tx_clk low for HOLD_CYC cycles, then loads the
// new ratio, so no tx_clk high pulse is ever truncated.
//
// Ports:
//   rx_clk125   in   125 MHz clock, sole clock domain
//   reset_n     in   asynchronous active-low reset
//   speed_req   in   requested speed: 00=10M, 01=100M, 10=1000M, 11=reserved
//   tx_clk      out  registered divided clock, 0 in bypass and while switching
//   tx_ce       out  one-cycle enable coincident with each tx_clk rise, 1 in bypass
//   clk_bypass  out  downstream mux selects rx_clk125 directly
//   speed_cur   out  speed currently in effect
//   busy        out  a speed switch is in progress
//   switch_done out  one-cycle pulse when the new speed takes effect
module eth_clk_ctrl #(
    parameter int unsigned DIV_10     = 50,
    parameter int unsigned DIV_100    = 5,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned HOLD_CYC   = 8
) (
    input  logic       rx_clk125,
    input  logic       reset_n,
    input  logic [1:0] speed_req,
    output logic       tx_clk,
    output logic       tx_ce,
    output logic       clk_bypass,
    output logic [1:0] speed_cur,
    output logic       busy,
    output logic       switch_done
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    typedef enum logic [1:0] {StRun, StDrain, StHold, StLoad} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [1:0]          cand_q, cand_d;
    logic [1:0]          tgt_q, tgt_d;
    logic                tx_clk_d, tx_ce_d, clk_bypass_d, busy_d, switch_done_d;
    logic [1:0]          speed_cur_d;

    function automatic logic [CNT_W-1:0] div_of(logic [1:0] spd);
        return (spd == SPD_100) ? CNT_W'(DIV_100) : CNT_W'(DIV_10);
    endfunction

    logic [CNT_W-1:0] cur_div, cur_last, cur_half, tgt_half;
    logic             cur_bypass, accept;

    assign cur_div    = div_of(speed_cur);
    assign cur_last   = cur_div - CNT_W'(1);
    assign cur_half   = cur_div >> 1;
    assign tgt_half   = div_of(tgt_q) >> 1;
    assign cur_bypass = (speed_cur == SPD_1000);

    // Acceptance uses the filter's pre-update view: candidate unchanged this cycle and
    // already seen STABLE_CYC-1 times in a row.
    assign accept = (speed_req == cand_q) && (stab_q == STAB_W'(STABLE_CYC - 1)) &&
                    (state_q == StRun) && (cand_q != speed_cur) && (cand_q != SPD_RSVD);

    // State register
    always_ff @(posedge rx_clk125 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (accept) state_d = StDrain;
            StDrain: if (cur_bypass || (cnt_q == cur_last)) state_d = StHold;
            StHold:  if (hold_q == HOLD_W'(HOLD_CYC - 1)) state_d = StLoad;
            StLoad:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Next values of the divider, filter and output registers
    always_comb begin
        cnt_d         = cnt_q;
        hold_d        = '0;
        tgt_d         = tgt_q;
        speed_cur_d   = speed_cur;
        tx_clk_d      = 1'b0;
        tx_ce_d       = 1'b0;
        clk_bypass_d  = 1'b0;

        unique case (state_q)
            StRun, StDrain: begin
                if (cur_bypass) begin
                    cnt_d = '0;
                    if (state_q == StRun) begin
                        tx_ce_d      = 1'b1;
                        clk_bypass_d = 1'b1;
                    end
                end else begin
                    // Outputs show the phase held in cnt_q, so the draining period ends
                    // on the low phase div-1.
                    cnt_d    = (cnt_q == cur_last) ? '0 : cnt_q + CNT_W'(1);
                    tx_clk_d = (cnt_q < cur_half);
                    tx_ce_d  = (cnt_q == '0);
                end
            end
            StHold: begin
                cnt_d  = '0;
                hold_d = hold_q + HOLD_W'(1);
            end
            StLoad: begin
                // Phase 0 of the new ratio is presented straight out of LOAD, so the
                // divider continues from phase 1.
                speed_cur_d  = tgt_q;
                clk_bypass_d = (tgt_q == SPD_1000);
                tx_ce_d      = 1'b1;
                tx_clk_d     = (tgt_q != SPD_1000) && (tgt_half != '0);
                cnt_d        = (tgt_q == SPD_1000) ? '0 : CNT_W'(1);
            end
            default: ;
        endcase

        if (accept) tgt_d = cand_q;

        if (speed_req != cand_q) begin
            cand_d = speed_req;
            stab_d = '0;
        end else begin
            cand_d = cand_q;
            stab_d = (stab_q == STAB_W'(STABLE_CYC)) ? stab_q : stab_q + STAB_W'(1);
        end

        busy_d        = (state_d != StRun);
        switch_done_d = (state_q == StLoad);
    end

    // Datapath and output registers
    always_ff @(posedge rx_clk125 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            stab_q      <= '0;
            cand_q      <= 2'b00;
            tgt_q       <= 2'b00;
            speed_cur   <= 2'b00;
            tx_clk      <= 1'b0;
            tx_ce       <= 1'b0;
            clk_bypass  <= 1'b0;
            busy        <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            stab_q      <= stab_d;
            cand_q      <= cand_d;
            tgt_q       <= tgt_d;
            speed_cur   <= speed_cur_d;
            tx_clk      <= tx_clk_d;
            tx_ce       <= tx_ce_d;
            clk_bypass  <= clk_bypass_d;
            busy        <= busy_d;
            switch_done <= switch_done_d;
        end
    end

endmodule

// File: tb/tb_eth_clk_ctrl.sv
// Self-checking bench for eth_clk_ctrl: a schedule-based model predicts every output on
// every cycle, and directed scenarios add hand-computed literal expectations.
module tb_eth_clk_ctrl;

    localparam int HOLD   = 8;
    localparam int STABLE = 16;

    logic       rx_clk125 = 1'b0;
    logic       reset_n   = 1'b0;
    logic [1:0] speed_req = 2'b00;
    logic       tx_clk, tx_ce, clk_bypass, busy, switch_done;
    logic [1:0] speed_cur;

    int n_checks = 0;
    int n_err    = 0;
    int n_print  = 0;

    eth_clk_ctrl dut (
        .rx_clk125   (rx_clk125),
        .reset_n     (reset_n),
        .speed_req   (speed_req),
        .tx_clk      (tx_clk),
        .tx_ce       (tx_ce),
        .clk_bypass  (clk_bypass),
        .speed_cur   (speed_cur),
        .busy        (busy),
        .switch_done (switch_done)
    );

    always #4 rx_clk125 = ~rx_clk125;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
            end
        end
    endtask

    // ---------------- model ----------------
    // Outside a switch the waveform is a pure function of speed and phase. On acceptance
    // the whole switch is laid out as a queue of {clk, ce, bypass, busy} entries: the rest
    // of the old period, then HOLD low cycles; the cycle after it drains starts the new
    // speed at phase 0.
    logic [3:0] sched[$];
    int         m_ph   = -1;
    int         m_stab = 0;
    logic [1:0] m_spd  = 2'b00;
    logic [1:0] m_tgt  = 2'b00;
    logic [1:0] m_cand = 2'b00;
    bit         m_load = 1'b0;
    logic       e_clk = 0, e_ce = 0, e_byp = 0, e_busy = 0, e_done = 0;
    logic [1:0] e_spd = 2'b00;

    function automatic int divof(logic [1:0] s);
        return (s == 2'b01) ? 5 : 50;
    endfunction

    task automatic model_reset();
        m_ph = -1; m_stab = 0; m_spd = 2'b00; m_tgt = 2'b00; m_cand = 2'b00; m_load = 1'b0;
        sched.delete();
        e_clk = 0; e_ce = 0; e_byp = 0; e_busy = 0; e_done = 0; e_spd = 2'b00;
    endtask

    task automatic show_steady();
        if (m_spd == 2'b10) begin
            e_clk = 1'b0; e_ce = 1'b1; e_byp = 1'b1;
        end else begin
            e_clk = (m_ph < divof(m_spd) / 2); e_ce = (m_ph == 0); e_byp = 1'b0;
        end
    endtask

    task automatic model_step();
        bit         run, acc;
        int         d, n, p;
        logic [3:0] x;
        if (!reset_n) begin
            model_reset();
            return;
        end
        run = (sched.size() == 0) && !m_load;
        acc = run && (speed_req == m_cand) && (m_stab == STABLE - 1) &&
              (m_cand != m_spd) && (m_cand != 2'b11);
        if (speed_req != m_cand) begin
            m_cand = speed_req; m_stab = 0;
        end else if (m_stab < STABLE) begin
            m_stab++;
        end
        e_done = 1'b0;
        if (sched.size() > 0) begin
            x = sched.pop_front();
            {e_clk, e_ce, e_byp, e_busy} = x;
            if (sched.size() == 0) m_load = 1'b1;
        end else if (m_load) begin
            m_load = 1'b0; m_spd = m_tgt; m_ph = 0;
            show_steady(); e_busy = 1'b0; e_done = 1'b1;
        end else begin
            if (m_spd != 2'b10) m_ph = (m_ph + 1) % divof(m_spd);
            show_steady(); e_busy = 1'b0;
        end
        e_spd = m_spd;
        if (acc) begin
            e_busy = 1'b1;
            m_tgt  = m_cand;
            if (m_spd == 2'b10) begin
                sched.push_back(4'b0001);
            end else begin
                d = divof(m_spd);
                n = (m_ph == d - 1) ? d : d - 1 - m_ph;
                for (int i = 1; i <= n; i++) begin
                    p = (m_ph + i) % d;
                    sched.push_back({(p < d / 2), (p == 0), 1'b0, 1'b1});
                end
            end
            for (int i = 0; i < HOLD; i++) sched.push_back(4'b0001);
        end
    endtask

    // Single compare process: advance the model on each edge, check mid-cycle.
    initial begin
        forever begin
            @(posedge rx_clk125);
            model_step();
            #2;
            check("tx_clk",      int'(tx_clk),      int'(e_clk));
            check("tx_ce",       int'(tx_ce),       int'(e_ce));
            check("clk_bypass",  int'(clk_bypass),  int'(e_byp));
            check("busy",        int'(busy),        int'(e_busy));
            check("switch_done", int'(switch_done), int'(e_done));
            check("speed_cur",   int'(speed_cur),   int'(e_spd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge rx_clk125);
    endtask

    task automatic measure_pulse(output int hi, output int lo);
        int g;
        hi = 0; lo = 0; g = 0;
        while (tx_ce !== 1'b1 && g < 200) begin @(negedge rx_clk125); g++; end
        while (tx_clk === 1'b1 && g < 400) begin hi++; @(negedge rx_clk125); g++; end
        while (tx_clk === 1'b0 && g < 400) begin lo++; @(negedge rx_clk125); g++; end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 100) begin @(negedge rx_clk125); n++; end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (switch_done !== 1'b1 && n < 300) begin @(negedge rx_clk125); n++; end
    endtask

    initial begin
        int hi, lo, n, cnt;
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int hi, lo, n, cnt;
        model_reset();
        reset_n   = 1'b0;
        speed_req = 2'b00;
        cyc(3);
        check("rst_tx_clk",    int'(tx_clk),    0);
        check("rst_tx_ce",     int'(tx_ce),     0);
        check("rst_busy",      int'(busy),      0);
        check("rst_speed_cur", int'(speed_cur), 0);
        reset_n = 1'b1;

        // 10M steady: 25 high / 25 low, two enables per 100 cycles
        measure_pulse(hi, lo);
        check("10m_hi", hi, 25);
        check("10m_lo", lo, 25);
        cnt = 0;
        repeat (100) begin @(negedge rx_clk125); cnt += int'(tx_ce); end
        check("10m_ce_per_100", cnt, 2);

        // Short 100M glitch is filtered out
        speed_req = 2'b01;
        cnt = 0;
        repeat (10) begin @(negedge rx_clk125); cnt += int'(busy); end
        speed_req = 2'b00;
        repeat (80) begin @(negedge rx_clk125); cnt += int'(busy); end
        check("glitch_busy", cnt, 0);
        measure_pulse(hi, lo);
        check("glitch_hi", hi, 25);
        check("glitch_lo", lo, 25);

        // 10M -> 100M
        speed_req = 2'b01;
        wait_busy(n);
        check("accept_latency", n, 17);
        cnt = 0;
        repeat (150) begin cnt += int'(switch_done); @(negedge rx_clk125); end
        check("100m_done_pulses", cnt, 1);
        check("100m_speed_cur", int'(speed_cur), 1);
        check("model_speed_100", int'(m_spd), 1);
        measure_pulse(hi, lo);
        check("100m_hi", hi, 2);
        check("100m_lo", lo, 3);

        // 100M -> bypass
        speed_req = 2'b10;
        wait_done(n);
        check("byp_done_seen", int'(n < 300), 1);
        check("byp_at_done", int'(clk_bypass), 1);
        check("byp_speed_cur", int'(speed_cur), 2);
        cnt = 0;
        repeat (20) begin
            @(negedge rx_clk125);
            cnt += int'(tx_ce === 1'b1 && clk_bypass === 1'b1 && tx_clk === 1'b0);
        end
        check("byp_steady", cnt, 20);

        // bypass -> 10M: one drain cycle, HOLD cycles, one load cycle
        speed_req = 2'b00;
        wait_busy(n);
        check("byp_accept", n, 17);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge rx_clk125); end
        check("byp_busy_len", cnt, 10);
        check("back10_done", int'(switch_done), 1);
        check("back10_bypass", int'(clk_bypass), 0);
        measure_pulse(hi, lo);
        check("back10_hi", hi, 25);
        check("back10_lo", lo, 25);

        // Reserved request is ignored
        speed_req = 2'b11;
        cnt = 0;
        repeat (100) begin @(negedge rx_clk125); cnt += int'(busy); end
        check("rsvd_busy", cnt, 0);
        check("rsvd_speed_cur", int'(speed_cur), 0);
        measure_pulse(hi, lo);
        check("rsvd_hi", hi, 25);
        check("rsvd_lo", lo, 25);

        // Reset in the middle of the hold interval of a 10M -> 100M switch
        speed_req = 2'b01;
        n = 0;
        while (!(sched.size() > 0 && sched.size() <= 5) && n < 300) begin
            @(negedge rx_clk125); n++;
        end
        check("reached_hold", int'(n < 300), 1);
        reset_n   = 1'b0;
        speed_req = 2'b00;
        #1;
        check("midhold_tx_clk", int'(tx_clk),      0);
        check("midhold_busy",   int'(busy),        0);
        check("midhold_done",   int'(switch_done), 0);
        check("midhold_speed",  int'(speed_cur),   0);
        cyc(2);
        reset_n = 1'b1;
        measure_pulse(hi, lo);
        check("post_rst_hi", hi, 25);
        check("post_rst_lo", lo, 25);
        check("post_rst_speed", int'(speed_cur), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
